// File: rtl/sd_card_fsm.sv
// sd_card_fsm: command layer of an SD card in SPI-less native mode.
// Decodes received command tokens, tracks the card CURRENT_STATE, builds
// response payloads and sequences the read/write block streams.
`timescale 1ns/1ps
module sd_card_fsm #(
    parameter logic [15:0] RCA         = 16'h1234,
    parameter int          ACMD41_BUSY = 2,
    parameter logic [31:0] OCR         = 32'h00FF_8000
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        icmd_valid,
    input  logic        icmd_crc_err,
    input  logic [5:0]  iindex,
    input  logic [31:0] iarg,
    input  logic        iresp_done,
    input  logic        iread_done,
    input  logic        iwrite_done,
    output logic        oresp_start,
    output logic [2:0]  oresp_type,
    output logic [31:0] oresp_arg,
    output logic        ostart_read,
    output logic        ostart_write,
    output logic        ostop_data,
    output logic [31:0] oaddr,
    output logic [3:0]  ocard_state,
    output logic        obusy
);
    typedef enum logic [3:0] {
        CS_IDLE  = 4'd0, CS_READY = 4'd1, CS_IDENT = 4'd2, CS_STBY = 4'd3, CS_TRAN = 4'd4,
        CS_DATA  = 4'd5, CS_RCV   = 4'd6, CS_PRG   = 4'd7, CS_INA  = 4'd8
    } card_state_t;
    typedef enum logic {CTL_WAIT = 1'b0, CTL_RESP = 1'b1} ctl_state_t;
    typedef enum logic [1:0] {DEC_ILLEGAL = 2'd0, DEC_SILENT = 2'd1, DEC_RESP = 2'd2} dec_kind_t;

    localparam logic [2:0] RT_R1    = 3'd1;
    localparam logic [2:0] RT_R1B   = 3'd2;
    localparam logic [2:0] RT_R2CID = 3'd3;
    localparam logic [2:0] RT_R2CSD = 3'd4;
    localparam logic [2:0] RT_R3    = 3'd5;
    localparam logic [2:0] RT_R6    = 3'd6;
    localparam logic [2:0] RT_R7    = 3'd7;

    card_state_t card_state;
    ctl_state_t  ctl_state;
    logic        rca_valid;
    logic        app_cmd;
    logic        err_crc;
    logic        err_ill;
    logic        pend_read;
    logic        pend_write;
    logic [1:0]  acmd41_cnt;

    card_state_t cs_eff;
    logic        rca_match;
    logic [31:0] r1_status;
    logic        cmd_accept;

    dec_kind_t   dec_kind;
    logic [2:0]  dec_type;
    logic [31:0] dec_arg;
    card_state_t dec_next;
    logic        dec_app;
    logic        dec_clear;
    logic        dec_rca_set;
    logic        dec_cnt_inc;
    logic        dec_load;
    logic        dec_rd;
    logic        dec_wr;
    logic        dec_stop;

    assign ocard_state = card_state;

    // State seen by an incoming command (a programming-done pulse lands first) and its R1 status.
    always_comb begin
        cs_eff     = (card_state == CS_PRG && iwrite_done) ? CS_TRAN : card_state;
        rca_match  = (iarg[31:16] == RCA);
        cmd_accept = icmd_valid && (ctl_state == CTL_WAIT) && (card_state != CS_INA);
        r1_status  = {8'h00, err_crc, err_ill, 9'h000, cs_eff, (cs_eff != CS_PRG), 2'b00,
                      (app_cmd | (iindex == 6'd55)), 5'h00};
    end

    // Command decode: legality against the current state, response and side effects.
    always_comb begin
        dec_kind    = DEC_ILLEGAL;
        dec_type    = RT_R1;
        dec_arg     = r1_status;
        dec_next    = cs_eff;
        dec_app     = 1'b0;
        dec_clear   = 1'b0;
        dec_rca_set = 1'b0;
        dec_cnt_inc = 1'b0;
        dec_load    = 1'b0;
        dec_rd      = 1'b0;
        dec_wr      = 1'b0;
        dec_stop    = 1'b0;
        case (iindex)
            6'd0: begin
                dec_kind  = DEC_SILENT;
                dec_next  = CS_IDLE;
                dec_clear = 1'b1;
            end
            6'd2: if (cs_eff == CS_READY) begin
                dec_kind = DEC_RESP; dec_type = RT_R2CID; dec_arg = 32'h0; dec_next = CS_IDENT;
            end
            6'd3: if (cs_eff == CS_IDENT || cs_eff == CS_STBY) begin
                dec_kind    = DEC_RESP;
                dec_type    = RT_R6;
                dec_arg     = {RCA, 16'h0500 | {10'b0, app_cmd, 5'b0}};
                dec_next    = CS_STBY;
                dec_rca_set = 1'b1;
            end
            6'd7: begin
                dec_kind = DEC_SILENT;
                if (rca_match && cs_eff == CS_STBY) begin
                    dec_kind = DEC_RESP; dec_type = RT_R1B; dec_next = CS_TRAN;
                end else if (!rca_match && cs_eff == CS_TRAN) begin
                    dec_next = CS_STBY;
                end
            end
            6'd8: if (cs_eff == CS_IDLE) begin
                dec_kind = DEC_RESP; dec_type = RT_R7; dec_arg = {20'h0, iarg[11:8], iarg[7:0]};
            end
            6'd9: if (cs_eff == CS_STBY && rca_match) begin
                dec_kind = DEC_RESP; dec_type = RT_R2CSD; dec_arg = 32'h0;
            end
            6'd12: if (cs_eff == CS_DATA || cs_eff == CS_RCV) begin
                dec_kind = DEC_RESP; dec_type = RT_R1B; dec_stop = 1'b1;
                dec_next = (cs_eff == CS_DATA) ? CS_TRAN : CS_PRG;
            end
            6'd13: if (rca_match && cs_eff >= CS_STBY && cs_eff <= CS_PRG) begin
                dec_kind = DEC_RESP;
            end
            6'd15: if (rca_match) begin
                dec_kind = DEC_SILENT; dec_next = CS_INA;
            end
            6'd18: if (cs_eff == CS_TRAN) begin
                dec_kind = DEC_RESP; dec_next = CS_DATA; dec_load = 1'b1; dec_rd = 1'b1;
            end
            6'd23: if (app_cmd && cs_eff == CS_TRAN) begin
                dec_kind = DEC_RESP;
            end
            6'd25: if (cs_eff == CS_TRAN) begin
                dec_kind = DEC_RESP; dec_next = CS_RCV; dec_load = 1'b1; dec_wr = 1'b1;
            end
            6'd41: if (app_cmd && cs_eff == CS_IDLE) begin
                dec_kind = DEC_RESP;
                dec_type = RT_R3;
                if (int'(acmd41_cnt) < ACMD41_BUSY) begin
                    dec_arg     = {2'b00, OCR[29:0]};
                    dec_cnt_inc = 1'b1;
                end else begin
                    dec_arg  = {1'b1, iarg[30], OCR[29:0]};
                    dec_next = CS_READY;
                end
            end
            6'd55: if (!rca_valid || rca_match) begin
                dec_kind = DEC_RESP; dec_app = 1'b1;
            end
            default: dec_kind = DEC_ILLEGAL;
        endcase
    end

    // Card state, control FSM, data-stream sequencing and registered outputs.
    always_ff @(posedge iclk) begin
        if (irst) begin
            card_state   <= CS_IDLE;
            ctl_state    <= CTL_WAIT;
            rca_valid    <= 1'b0;
            app_cmd      <= 1'b0;
            err_crc      <= 1'b0;
            err_ill      <= 1'b0;
            pend_read    <= 1'b0;
            pend_write   <= 1'b0;
            acmd41_cnt   <= 2'd0;
            oresp_start  <= 1'b0;
            oresp_type   <= 3'd0;
            oresp_arg    <= 32'h0;
            ostart_read  <= 1'b0;
            ostart_write <= 1'b0;
            ostop_data   <= 1'b0;
            oaddr        <= 32'h0;
            obusy        <= 1'b0;
        end else begin
            oresp_start  <= 1'b0;
            ostart_read  <= 1'b0;
            ostart_write <= 1'b0;
            ostop_data   <= 1'b0;
            if (iread_done && card_state == CS_DATA) oaddr <= oaddr + 32'd1;
            if (iwrite_done && card_state == CS_RCV) oaddr <= oaddr + 32'd1;
            if (iwrite_done && card_state == CS_PRG) begin
                card_state <= CS_TRAN;
                obusy      <= 1'b0;
            end
            case (ctl_state)
                CTL_WAIT: if (cmd_accept) begin
                    if (icmd_crc_err) begin
                        err_crc <= 1'b1;
                        app_cmd <= 1'b0;
                    end else if (dec_kind == DEC_ILLEGAL) begin
                        err_ill <= 1'b1;
                        app_cmd <= 1'b0;
                    end else begin
                        app_cmd    <= dec_app;
                        card_state <= dec_next;
                        obusy      <= (dec_next == CS_PRG);
                        ostop_data <= dec_stop;
                        if (dec_load) oaddr <= iarg;
                        if (dec_rca_set) rca_valid <= 1'b1;
                        if (dec_cnt_inc) acmd41_cnt <= acmd41_cnt + 2'd1;
                        if (dec_clear) begin
                            rca_valid  <= 1'b0;
                            acmd41_cnt <= 2'd0;
                            err_crc    <= 1'b0;
                            err_ill    <= 1'b0;
                        end
                        if (dec_kind == DEC_RESP) begin
                            oresp_start <= 1'b1;
                            oresp_type  <= dec_type;
                            oresp_arg   <= dec_arg;
                            pend_read   <= dec_rd;
                            pend_write  <= dec_wr;
                            ctl_state   <= CTL_RESP;
                            if (dec_type == RT_R1 || dec_type == RT_R1B) begin
                                err_crc <= 1'b0;
                                err_ill <= 1'b0;
                            end
                        end
                    end
                end
                CTL_RESP: if (iresp_done) begin
                    ctl_state    <= CTL_WAIT;
                    ostart_read  <= pend_read;
                    ostart_write <= pend_write;
                    pend_read    <= 1'b0;
                    pend_write   <= 1'b0;
                end
                default: ctl_state <= CTL_WAIT;
            endcase
        end
    end
endmodule
